riscv_shared_mem_arbiter: RTL

//  Sits directly downstream of riscv_minimal. Merges its imem_access_req and dmem_access_req

---
 rtl/riscv_shared_mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/riscv_shared_mem_arbiter.sv
// Merges the riscv_minimal instruction and data memory ports onto one single-port
// synchronous SRAM, inserting wait states for read latency and port contention.
module riscv_shared_mem_arbiter #(
    parameter int SRAM_ADDR_BITS = 14,
    parameter bit ROUND_ROBIN    = 1'b0
) (
    input  logic                      clk,
    input  logic                      clk__enable,
    input  logic                      reset_n,
    input  logic [31:0]               imem_access_req__address,
    input  logic [3:0]                imem_access_req__byte_enable,
    input  logic                      imem_access_req__write_enable,
    input  logic                      imem_access_req__read_enable,
    input  logic [31:0]               imem_access_req__write_data,
    input  logic [31:0]               dmem_access_req__address,
    input  logic [3:0]                dmem_access_req__byte_enable,
    input  logic                      dmem_access_req__write_enable,
    input  logic                      dmem_access_req__read_enable,
    input  logic [31:0]               dmem_access_req__write_data,
    output logic                      imem_access_resp__wait,
    output logic [31:0]               imem_access_resp__read_data,
    output logic                      dmem_access_resp__wait,
    output logic [31:0]               dmem_access_resp__read_data,
    output logic                      sram_select,
    output logic                      sram_read_not_write,
    output logic [SRAM_ADDR_BITS-1:0] sram_address,
    output logic [3:0]                sram_write_enable,
    output logic [31:0]               sram_write_data,
    input  logic [31:0]               sram_read_data
);

    typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

    localparam logic GRANT_IMEM = 1'b0;
    localparam logic GRANT_DMEM = 1'b1;

    state_t state, state_next;
    logic   last_grant, last_grant_next;
    logic   imem_active, dmem_active;
    logic   imem_cand, dmem_cand;
    logic   grant_imem, grant_dmem;
    logic   unused_addr_bits;

    assign imem_active = imem_access_req__read_enable | imem_access_req__write_enable;
    assign dmem_active = dmem_access_req__read_enable | dmem_access_req__write_enable;

    // Word-offset and above-SRAM address bits are deliberately dropped (wrap-around).
    assign unused_addr_bits = ^{imem_access_req__address[31:SRAM_ADDR_BITS+2],
                                imem_access_req__address[1:0],
                                dmem_access_req__address[31:SRAM_ADDR_BITS+2],
                                dmem_access_req__address[1:0]};

    // Read data is simply forwarded; it only matters in the completing RD_x cycle.
    assign imem_access_resp__read_data = sram_read_data;
    assign dmem_access_resp__read_data = sram_read_data;

    always_comb begin
        imem_cand           = imem_active && (state != RD_I);
        dmem_cand           = dmem_active && (state != RD_D);
        grant_imem          = 1'b0;
        grant_dmem          = 1'b0;
        sram_select         = 1'b0;
        sram_read_not_write = 1'b1;
        sram_address        = '0;
        sram_write_enable   = 4'h0;
        sram_write_data     = 32'h0;
        state_next          = IDLE;
        last_grant_next     = last_grant;

        if (imem_cand && dmem_cand) begin
            if (ROUND_ROBIN && (last_grant == GRANT_DMEM)) grant_imem = 1'b1;
            else                                           grant_dmem = 1'b1;
        end else begin
            grant_imem = imem_cand;
            grant_dmem = dmem_cand;
        end

        if (grant_imem) begin
            sram_select         = 1'b1;
            sram_read_not_write = ~imem_access_req__write_enable;
            sram_address        = imem_access_req__address[SRAM_ADDR_BITS+1:2];
            sram_write_enable   = imem_access_req__write_enable ? imem_access_req__byte_enable : 4'h0;
            sram_write_data     = imem_access_req__write_data;
            last_grant_next     = GRANT_IMEM;
            if (!imem_access_req__write_enable) state_next = RD_I;
        end else if (grant_dmem) begin
            sram_select         = 1'b1;
            sram_read_not_write = ~dmem_access_req__write_enable;
            sram_address        = dmem_access_req__address[SRAM_ADDR_BITS+1:2];
            sram_write_enable   = dmem_access_req__write_enable ? dmem_access_req__byte_enable : 4'h0;
            sram_write_data     = dmem_access_req__write_data;
            last_grant_next     = GRANT_DMEM;
            if (!dmem_access_req__write_enable) state_next = RD_D;
        end

        // A completing read never waits; a granted write finishes now; a granted read waits.
        if (state == RD_I)    imem_access_resp__wait = 1'b0;
        else if (grant_imem)  imem_access_resp__wait = ~imem_access_req__write_enable;
        else                  imem_access_resp__wait = imem_active;

        if (state == RD_D)    dmem_access_resp__wait = 1'b0;
        else if (grant_dmem)  dmem_access_resp__wait = ~dmem_access_req__write_enable;
        else                  dmem_access_resp__wait = dmem_active;

        if (!reset_n) begin
            sram_select            = 1'b0;
            sram_write_enable      = 4'h0;
            imem_access_resp__wait = 1'b1;
            dmem_access_resp__wait = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_IMEM;
        end else if (clk__enable) begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

endmodule
